ant_color_pipe: RTL and testbench

Pipelined, parametrised pixel colouriser between the sim-state render lookup and the VGA output registers. Maps one pixel's layer flags and N pheromone-signal channels to 24-bit RGB. Each channel has a display window (min, max, shift) that is runtime-programmable. The dominant channel selects the gradient. Debug location markers blink at a frame-counted rate. Output is registered with a fixed 3-cycle latency and a valid flag, so the VGA path has no long combinational colour chain.

---
 rtl/ant_color_pipe.sv | 257 +++++++++++++++++++++++++
 tb/tb_ant_color_pipe.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ant_color_pipe.sv
// ant_color_pipe
// Three-stage pixel colouriser sitting between the render lookup and the VGA
// output registers. Each of NUM_CH pheromone channels is clipped against a
// runtime-programmable display window, the strongest channel picks a
// grass-to-teal or grass-to-violet gradient, and solid layers / blinking
// debug markers override the gradient in a fixed priority order.
//
// Ports
//   Clk, Reset_n            clock, asynchronous active-low reset
//   pix_valid               pixel inputs valid this cycle
//   renderAnt/Sugar/Nest    layer flags
//   render_viewLoc/writeLoc debug location flags
//   renderSignal            NUM_CH packed channels, ch0 in the LSBs
//   frame_start             one-cycle pulse at each frame start
//   debug_en                enables the debug markers
//   cfg_we/ch/min/max/shift window programming (cfg_ch >= NUM_CH ignored)
//   VGA_R/G/B, out_valid    registered colour, 3 cycles after pix_valid
module ant_color_pipe #(
   parameter int SIGNAL_BITS = 9,
   parameter int NUM_CH      = 2,
   parameter int DEF_MIN     = 8,
   parameter int DEF_MAX     = 511,
   parameter int DEF_SHIFT   = 1,
   parameter int BLINK_LOG2  = 4
) (
   input  logic                          Clk,
   input  logic                          Reset_n,
   input  logic                          pix_valid,
   input  logic                          renderAnt,
   input  logic                          renderSugar,
   input  logic                          renderNest,
   input  logic                          render_viewLoc,
   input  logic                          render_writeLoc,
   input  logic [NUM_CH*SIGNAL_BITS-1:0] renderSignal,
   input  logic                          frame_start,
   input  logic                          debug_en,
   input  logic                          cfg_we,
   input  logic [1:0]                    cfg_ch,
   input  logic [SIGNAL_BITS-1:0]        cfg_min,
   input  logic [SIGNAL_BITS-1:0]        cfg_max,
   input  logic [3:0]                    cfg_shift,
   output logic [7:0]                    VGA_R,
   output logic [7:0]                    VGA_G,
   output logic [7:0]                    VGA_B,
   output logic                          out_valid
);

   localparam logic [SIGNAL_BITS-1:0] DEF_MIN_C   = SIGNAL_BITS'(DEF_MIN);
   localparam logic [SIGNAL_BITS-1:0] DEF_MAX_C   = SIGNAL_BITS'(DEF_MAX);
   localparam logic [3:0]             DEF_SHIFT_C = 4'(DEF_SHIFT);

   localparam logic [23:0] GRASS_C  = 24'h669900;
   localparam logic [23:0] TEAL_C   = 24'h66FFFF;
   localparam logic [23:0] VIOLET_C = 24'hCC33FF;
   localparam logic [23:0] VIEW_C   = 24'hCC2000;
   localparam logic [23:0] WRITE_C  = 24'hEE6000;
   localparam logic [23:0] ANT_C    = 24'h000000;
   localparam logic [23:0] SUGAR_C  = 24'hFFFFFF;
   localparam logic [23:0] NEST_C   = 24'h8B4513;

   // Bit positions inside the flag bundle carried down the pipe
   localparam int F_ANT   = 4;
   localparam int F_SUGAR = 3;
   localparam int F_NEST  = 2;
   localparam int F_VIEW  = 1;
   localparam int F_WRITE = 0;

   // Window clip. The s > max test comes first so that an inverted window
   // (min > max) degenerates into a pure 0/255 step and never a gradient.
   function automatic logic [7:0] clip_f(
      input logic [SIGNAL_BITS-1:0] sig,
      input logic [SIGNAL_BITS-1:0] lo,
      input logic [SIGNAL_BITS-1:0] hi,
      input logic [3:0]             shift
   );
      logic [SIGNAL_BITS-1:0] off_v;
      logic [SIGNAL_BITS-1:0] sh_v;
      off_v = sig - lo;
      sh_v  = off_v >> shift;
      if (sig > hi) begin
         clip_f = 8'hFF;
      end else if (sig < lo) begin
         clip_f = 8'h00;
      end else if (sh_v > SIGNAL_BITS'(255)) begin
         clip_f = 8'hFF;
      end else begin
         clip_f = sh_v[7:0];
      end
   endfunction

   // One gradient component: base + ((target - base) * inten) >>> 8.
   // Bits [15:8] of the 17-bit product are the arithmetic shift truncated
   // to 8 bits; the add wraps modulo 256.
   function automatic logic [7:0] grad_f(
      input logic [7:0] base,
      input logic [7:0] target,
      input logic [7:0] inten
   );
      logic signed [8:0]  diff_v;
      logic signed [16:0] prod_v;
      diff_v = $signed({1'b0, target}) - $signed({1'b0, base});
      prod_v = diff_v * $signed({1'b0, inten});
      grad_f = base + prod_v[15:8];
   endfunction

   logic [SIGNAL_BITS-1:0] win_min_r   [NUM_CH];
   logic [SIGNAL_BITS-1:0] win_max_r   [NUM_CH];
   logic [3:0]             win_shift_r [NUM_CH];

   logic [7:0] clip_s   [NUM_CH];
   logic [7:0] s1_int_r [NUM_CH];
   logic       s1_valid_r;
   logic [4:0] s1_flags_r;

   logic [7:0] best_int_s;
   logic [1:0] best_ch_s;
   logic       s2_valid_r;
   logic [4:0] s2_flags_r;
   logic [1:0] s2_ch_r;
   logic [7:0] s2_int_r;

   logic [7:0]  frame_cnt_r;
   logic        blink_s;
   logic [23:0] tgt_s;
   logic [23:0] rgb_s;

   // Runtime display-window registers; a write is seen by the next pixel
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         for (int c = 0; c < NUM_CH; c++) begin
            win_min_r[c]   <= DEF_MIN_C;
            win_max_r[c]   <= DEF_MAX_C;
            win_shift_r[c] <= DEF_SHIFT_C;
         end
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            if (cfg_we && (cfg_ch == 2'(c))) begin
               win_min_r[c]   <= cfg_min;
               win_max_r[c]   <= cfg_max;
               win_shift_r[c] <= cfg_shift;
            end
         end
      end
   end

   // Stage 1 combinational clip of every channel against its window
   always_comb begin
      for (int c = 0; c < NUM_CH; c++) begin
         clip_s[c] = clip_f(renderSignal[c*SIGNAL_BITS +: SIGNAL_BITS],
                            win_min_r[c], win_max_r[c], win_shift_r[c]);
      end
   end

   // Stage 1 register: intensities plus the layer and debug flags
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         s1_valid_r <= 1'b0;
         s1_flags_r <= 5'b00000;
         for (int c = 0; c < NUM_CH; c++) begin
            s1_int_r[c] <= 8'h00;
         end
      end else begin
         s1_valid_r <= pix_valid;
         s1_flags_r <= {renderAnt, renderSugar, renderNest,
                        render_viewLoc, render_writeLoc};
         for (int c = 0; c < NUM_CH; c++) begin
            s1_int_r[c] <= clip_s[c];
         end
      end
   end

   // Stage 2 argmax; strict compare keeps the lowest index on a tie
   always_comb begin
      best_int_s = s1_int_r[0];
      best_ch_s  = 2'd0;
      for (int c = 1; c < NUM_CH; c++) begin
         if (s1_int_r[c] > best_int_s) begin
            best_int_s = s1_int_r[c];
            best_ch_s  = 2'(c);
         end else begin
            best_int_s = best_int_s;
         end
      end
   end

   // Stage 2 register: dominant channel and its intensity
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         s2_valid_r <= 1'b0;
         s2_flags_r <= 5'b00000;
         s2_ch_r    <= 2'd0;
         s2_int_r   <= 8'h00;
      end else begin
         s2_valid_r <= s1_valid_r;
         s2_flags_r <= s1_flags_r;
         s2_ch_r    <= best_ch_s;
         s2_int_r   <= best_int_s;
      end
   end

   // Frame counter, free-running modulo 256
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         frame_cnt_r <= 8'h00;
      end else if (frame_start) begin
         frame_cnt_r <= frame_cnt_r + 8'h01;
      end
   end

   // Blink half-period is 2^BLINK_LOG2 frames. Stage 3 reads the registered
   // count, so a pixel leaving the pipe on a frame_start edge sees the old phase.
   assign blink_s = frame_cnt_r[BLINK_LOG2];

   // Stage 3 colour selection in fixed priority order
   always_comb begin
      tgt_s = TEAL_C;
      rgb_s = 24'h000000;
      case (s2_ch_r)
         2'd0, 2'd2: tgt_s = TEAL_C;
         2'd1, 2'd3: tgt_s = VIOLET_C;
         default:    tgt_s = TEAL_C;
      endcase
      if (!s2_valid_r) begin
         rgb_s = 24'h000000;
      end else if (debug_en && s2_flags_r[F_VIEW] && blink_s) begin
         rgb_s = VIEW_C;
      end else if (debug_en && s2_flags_r[F_WRITE] && blink_s) begin
         rgb_s = WRITE_C;
      end else if (s2_flags_r[F_ANT]) begin
         rgb_s = ANT_C;
      end else if (s2_flags_r[F_SUGAR]) begin
         rgb_s = SUGAR_C;
      end else if (s2_flags_r[F_NEST]) begin
         rgb_s = NEST_C;
      end else begin
         rgb_s = {grad_f(GRASS_C[23:16], tgt_s[23:16], s2_int_r),
                  grad_f(GRASS_C[15:8],  tgt_s[15:8],  s2_int_r),
                  grad_f(GRASS_C[7:0],   tgt_s[7:0],   s2_int_r)};
      end
   end

   // Output register; bubbles blank to black
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         out_valid <= 1'b0;
         VGA_R     <= 8'h00;
         VGA_G     <= 8'h00;
         VGA_B     <= 8'h00;
      end else begin
         out_valid <= s2_valid_r;
         VGA_R     <= rgb_s[23:16];
         VGA_G     <= rgb_s[15:8];
         VGA_B     <= rgb_s[7:0];
      end
   end

endmodule

// File: tb/tb_ant_color_pipe.sv
// Self-checking bench for ant_color_pipe: an arithmetic reference model
// predicts every output cycle, and hand-computed literals pin both the DUT
// and the model at selected pixels.
module tb_ant_color_pipe;

   localparam int SB  = 9;
   localparam int NCH = 2;
   localparam int BL  = 4;

   logic            Clk;
   logic            Reset_n;
   logic            pix_valid, renderAnt, renderSugar, renderNest;
   logic            render_viewLoc, render_writeLoc;
   logic [NCH*SB-1:0] renderSignal;
   logic            frame_start, debug_en, cfg_we;
   logic [1:0]      cfg_ch;
   logic [SB-1:0]   cfg_min, cfg_max;
   logic [3:0]      cfg_shift;
   logic [7:0]      VGA_R, VGA_G, VGA_B;
   logic            out_valid;

   ant_color_pipe #(
      .SIGNAL_BITS(SB), .NUM_CH(NCH), .DEF_MIN(8), .DEF_MAX(511),
      .DEF_SHIFT(1), .BLINK_LOG2(BL)
   ) dut (
      .Clk(Clk), .Reset_n(Reset_n), .pix_valid(pix_valid),
      .renderAnt(renderAnt), .renderSugar(renderSugar), .renderNest(renderNest),
      .render_viewLoc(render_viewLoc), .render_writeLoc(render_writeLoc),
      .renderSignal(renderSignal), .frame_start(frame_start), .debug_en(debug_en),
      .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_min(cfg_min), .cfg_max(cfg_max),
      .cfg_shift(cfg_shift), .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
      .out_valid(out_valid)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   typedef struct packed {
      logic v; logic ant; logic sugar; logic nest; logic view; logic wr;
      int   d; int i;
   } rec_t;

   int          m_min [NCH];
   int          m_max [NCH];
   int          m_sh  [NCH];
   int          m_fcnt;
   rec_t        r1, r2;
   logic [24:0] exp_r;
   logic        chk_en;
   int          cyc = 0;
   int          checks = 0;
   int          failures = 0;
   int          due_q [$];
   logic [24:0] val_q [$];
   string       nm_q  [$];

   function automatic int clip(int s, int lo, int hi, int sh);
      int v;
      if (s > hi) return 255;
      if (s < lo) return 0;
      v = (s - lo) / (1 << sh);
      return (v > 255) ? 255 : v;
   endfunction

   function automatic int blend(int b, int t, int i);
      int p, q;
      p = (t - b) * i;
      if (p >= 0) q = p / 256;
      else        q = -((-p + 255) / 256);
      return (b + q) & 255;
   endfunction

   function automatic rec_t mk_rec();
      rec_t r;
      int   iv [NCH];
      int   top;
      r = '0;
      r.v = pix_valid; r.ant = renderAnt; r.sugar = renderSugar;
      r.nest = renderNest; r.view = render_viewLoc; r.wr = render_writeLoc;
      top = 0;
      for (int c = 0; c < NCH; c++) begin
         iv[c] = clip(int'(renderSignal[c*SB +: SB]), m_min[c], m_max[c], m_sh[c]);
         top = (iv[c] > top) ? iv[c] : top;
      end
      r.d = -1;
      for (int c = 0; c < NCH; c++) if (r.d < 0 && iv[c] == top) r.d = c;
      r.i = top;
      return r;
   endfunction

   function automatic logic [24:0] colour(rec_t r, int fcnt, logic dbg);
      logic blink;
      int   tr, tg, tb;
      if (!r.v) return 25'h0000000;
      blink = ((fcnt / (1 << BL)) % 2) == 1;
      if (dbg && r.view && blink) return {1'b1, 24'hCC2000};
      if (dbg && r.wr && blink)   return {1'b1, 24'hEE6000};
      if (r.ant)   return {1'b1, 24'h000000};
      if (r.sugar) return {1'b1, 24'hFFFFFF};
      if (r.nest)  return {1'b1, 24'h8B4513};
      if (r.d % 2 == 0) begin tr = 'h66; tg = 'hFF; tb = 'hFF; end
      else              begin tr = 'hCC; tg = 'h33; tb = 'hFF; end
      return {1'b1, 8'(blend('h66, tr, r.i)), 8'(blend('h99, tg, r.i)),
              8'(blend('h00, tb, r.i))};
   endfunction

   // Reference model: pixel enters, is held two cycles, leaves coloured
   always @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         for (int c = 0; c < NCH; c++) begin
            m_min[c] <= 8; m_max[c] <= 511; m_sh[c] <= 1;
         end
         m_fcnt <= 0;
         r1 <= '0; r2 <= '0; exp_r <= '0;
      end else begin
         exp_r <= colour(r2, m_fcnt, debug_en);
         r2    <= r1;
         r1    <= mk_rec();
         if (cfg_we && int'(cfg_ch) < NCH) begin
            m_min[int'(cfg_ch)] <= int'(cfg_min);
            m_max[int'(cfg_ch)] <= int'(cfg_max);
            m_sh[int'(cfg_ch)]  <= int'(cfg_shift);
         end
         if (frame_start) m_fcnt <= (m_fcnt + 1) % 256;
      end
   end

   always @(posedge Clk) cyc <= cyc + 1;

   // Compare process: model every cycle, plus literal pins when due
   always @(negedge Clk) begin
      if (chk_en) begin
         checks++;
         if ({out_valid, VGA_R, VGA_G, VGA_B} !== exp_r) begin
            failures++;
            $display("FAIL model cyc=%0d got v=%0b rgb=%02h%02h%02h want v=%0b rgb=%06h",
                     cyc, out_valid, VGA_R, VGA_G, VGA_B, exp_r[24], exp_r[23:0]);
         end
         while (due_q.size() > 0 && due_q[0] <= cyc) begin
            checks++;
            if (due_q[0] < cyc) begin
               failures++;
               $display("FAIL %s missed due=%0d now=%0d", nm_q[0], due_q[0], cyc);
            end else if ({out_valid, VGA_R, VGA_G, VGA_B} !== val_q[0]) begin
               failures++;
               $display("FAIL %s got v=%0b rgb=%02h%02h%02h want v=%0b rgb=%06h",
                        nm_q[0], out_valid, VGA_R, VGA_G, VGA_B, val_q[0][24], val_q[0][23:0]);
            end
            checks++;
            if (exp_r !== val_q[0]) begin
               failures++;
               $display("FAIL %s_model got %07h want %07h", nm_q[0], exp_r, val_q[0]);
            end
            void'(due_q.pop_front());
            void'(val_q.pop_front());
            void'(nm_q.pop_front());
         end
      end
   end

   task automatic idle();
      pix_valid = 1'b0; renderAnt = 1'b0; renderSugar = 1'b0; renderNest = 1'b0;
      render_viewLoc = 1'b0; render_writeLoc = 1'b0; renderSignal = '0;
      frame_start = 1'b0; cfg_we = 1'b0;
   endtask

   task automatic tick(input int n);
      repeat (n) begin @(posedge Clk); #1; end
   endtask

   task automatic push_raw(input string nm, input int due, input logic [24:0] v);
      due_q.push_back(due); val_q.push_back(v); nm_q.push_back(nm);
   endtask

   // Drive one pixel; flags are {ant,sugar,nest,view,write}
   task automatic px(input string nm, input logic [4:0] fl, input int s0, input int s1,
                     input logic chk, input logic [23:0] v);
      pix_valid = 1'b1;
      {renderAnt, renderSugar, renderNest, render_viewLoc, render_writeLoc} = fl;
      renderSignal = {SB'(s1), SB'(s0)};
      @(posedge Clk); #1;
      if (chk) push_raw(nm, cyc + 2, {1'b1, v});
      idle();
   endtask

   task automatic pulse();
      frame_start = 1'b1;
      tick(1);
      frame_start = 1'b0;
   endtask

   task automatic cfg(input int ch, input int lo, input int hi, input int sh);
      cfg_we = 1'b1; cfg_ch = 2'(ch); cfg_min = SB'(lo); cfg_max = SB'(hi);
      cfg_shift = 4'(sh);
      tick(1);
      cfg_we = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      chk_en = 1'b0; Reset_n = 1'b1; debug_en = 1'b0;
      cfg_ch = 2'd0; cfg_min = '0; cfg_max = '0; cfg_shift = 4'd0;
      idle();
      #2 Reset_n = 1'b0;
      #1 chk_en = 1'b1;
      @(posedge Clk); #1;
      tick(2);
      Reset_n = 1'b1;
      push_raw("reset_state", cyc, 25'h0000000);

      px("base", 5'b00000, 8, 0, 1'b1, 24'h669900);
      tick(3);
      px("ch0_300", 5'b00000, 300, 100, 1'b1, 24'h66D391);
      px("ch0_511", 5'b00000, 511, 0, 1'b1, 24'h66FDFA);
      px("tie_teal", 5'b00000, 200, 200, 1'b1, 24'h66BF5F);
      cfg_we = 1'b1; cfg_ch = 2'd1; cfg_min = SB'(8); cfg_max = SB'(511); cfg_shift = 4'd0;
      px("cfg_same_cycle", 5'b00000, 200, 200, 1'b1, 24'h66BF5F);
      px("tie_violet", 5'b00000, 200, 200, 1'b1, 24'hB24CBF);
      cfg(2, 0, 511, 0);
      px("cfg_ch_oob", 5'b00000, 200, 100, 1'b1, 24'h66BF5F);
      px("ant_all", 5'b11100, 0, 0, 1'b1, 24'h000000);
      px("sugar_nest", 5'b01100, 0, 0, 1'b1, 24'hFFFFFF);
      px("nest", 5'b00100, 0, 0, 1'b1, 24'h8B4513);

      debug_en = 1'b1;
      px("blink_off0", 5'b10010, 0, 0, 1'b1, 24'h000000);
      for (int f = 1; f <= 40; f++) begin
         pulse();
         if (f == 8) px("blink8_sugar", 5'b01011, 0, 0, 1'b1, 24'hFFFFFF);
         else if (f == 16) begin
            px("blink_on", 5'b10010, 0, 0, 1'b1, 24'hCC2000);
            px("write_on", 5'b10001, 0, 0, 1'b1, 24'hEE6000);
            px("view_over_write", 5'b10011, 0, 0, 1'b1, 24'hCC2000);
         end
         else if (f == 32) px("blink_off32", 5'b10010, 0, 0, 1'b1, 24'h000000);
         else px("", 5'b10010, 0, 0, 1'b0, 24'h000000);
      end
      for (int f = 0; f < 236; f++) begin
         if (f % 4 == 0) begin
            frame_start = 1'b1;
            px("", 5'b10010, f, 0, 1'b0, 24'h000000);
         end else pulse();
      end
      px("blink_cnt20", 5'b10010, 0, 0, 1'b1, 24'hCC2000);

      cfg(0, 300, 100, 0);
      px("step_lo", 5'b00000, 50, 0, 1'b1, 24'h669900);
      px("step_hi", 5'b00000, 200, 0, 1'b1, 24'h66FEFE);
      tick(3);

      for (int k = 0; k < 10; k++) begin
         if (k == 6) begin
            #3 Reset_n = 1'b0;
            tick(2);
            Reset_n = 1'b1;
            push_raw("post_reset", cyc, 25'h0000000);
         end
         px("", (k == 4) ? 5'b00100 : 5'b00000, (37 * k + 20) % 512, (53 * k) % 512,
            1'b0, 24'h000000);
         if (k % 3 == 2) tick(1);
      end
      tick(3);
      px("rst_blink", 5'b10010, 0, 0, 1'b1, 24'h000000);
      px("rst_cfg0", 5'b00000, 50, 0, 1'b1, 24'h66A114);
      px("rst_cfg1", 5'b00000, 200, 200, 1'b1, 24'h66BF5F);
      tick(5);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
